orb_descriptor_drain: RTL and testbench
=======================================

# orb_descriptor_drain

Receiving end of the rBRIEF descriptor output. Captures each 256-bit descriptor presented on `descriptors`/`out_valid` into a small FIFO and streams it out as 32-bit words over a valid/ready handshake toward the host/DMA side. Sits directly after the rBRIEF top and returns a full flag that upstream logic uses to suppress new corners while the drain is backed up.

## Interface
Parameters:
- `WIDTH_DESC`, 256, descriptor width in bits; must be a multiple of `WIDTH_WORD`.
- `WIDTH_WORD`, 32, output word width.
- `FIFO_DEPTH`, 4, number of whole descriptors buffered; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `ena`  in  1  capture enable; same signal as the pipeline `ena`.
- `descriptors`  in  WIDTH_DESC  descriptor from rBRIEF.
- `in_valid`  in  1  connects to rBRIEF `out_valid`; one-cycle pulse per descriptor.
- `desc_full`  out  1  FIFO holds FIFO_DEPTH descriptors.
- `word_out`  out  WIDTH_WORD  current output word.
- `word_valid`  out  1  `word_out` is valid.
- `word_ready`  in  1  consumer accepts word this cycle.
- `word_last`  out  1  `word_out` is the final word of a descriptor.
- `overflow`  out  1  sticky: a descriptor was dropped.
- `desc_count`  out  $clog2(FIFO_DEPTH)+1  descriptors currently stored.

## Operation
- NW = WIDTH_DESC/WIDTH_WORD (8 by default). Word k = `descriptors[k*WIDTH_WORD +: WIDTH_WORD]`, k = 0..NW-1, LSB word first.
- Push: `in_valid & ena` at a rising edge. Accepted if count < FIFO_DEPTH, or count == FIFO_DEPTH and the head is popped in the same cycle. Otherwise dropped and `overflow` set to 1.
- `in_valid` with `ena`=0 is ignored: no push, no overflow.
- Pop: the handshake `word_valid & word_ready & word_last` retires the head descriptor.
- Serializer FSM:
  - IDLE: count==0; `word_valid`=0. Goes to SEND when count becomes non-zero.
  - SEND: `word_valid`=1, `word_out` = word `idx` of the head descriptor. `idx` advances on each handshake.
  - On the last-word handshake, `idx` returns to 0. The FSM stays in SEND if count after the pop is >0, otherwise returns to IDLE.
- The drain side is independent of `ena`. Words keep flowing while `ena`=0.
- `word_out`, `word_last` and `word_valid` are held stable while `word_valid & ~word_ready`.
- `desc_full` = (count == FIFO_DEPTH) and is registered/combinational from the count register only, never from `in_valid`.
- `overflow` is cleared only by reset.
- Count arithmetic: next = count + push − pop. Simultaneous push and pop leaves count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (`rst`=0, asynchronous): count=0, pointers=0, `idx`=0, FSM=IDLE. Outputs: `word_valid`=0, `word_last`=0, `word_out`=0, `desc_full`=0, `overflow`=0, `desc_count`=0.
- Reset asserted mid-descriptor discards all stored data. No partial word is emitted after release.
- Latency: a push at edge N makes `word_valid`=1 with word 0 after edge N (first-word latency 1 cycle).
- With `word_ready` held at 1, one descriptor drains in NW cycles. Back-to-back descriptors stream with no bubble.
- `desc_full` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the pop that frees a slot.

## Structure
- Shared package: default `WIDTH_DESC`=256 and `WIDTH_WORD`=32 constants (the same 256 used by the generator), NW derived, and the FSM state enum {IDLE, SEND}.
- One sub-module: `desc_fifo`, a parameterised register FIFO with width WIDTH_DESC and show-ahead head output, exposing push, pop, full and count.
- Serializer FSM, word mux, overflow flag and `word_last` live in the top.

## Test plan
- Single descriptor 0x…_00000007_00000006_…_00000000 (word k = k), `word_ready`=1 → `word_valid` rises 1 cycle after the push. Words 0..7 appear on consecutive cycles; `word_last` is high only with value 7; count returns to 0.
- Backpressure: `word_ready` toggles 1,0,0,1… → each word is held unchanged while stalled; exactly 8 handshakes occur; no word is duplicated or skipped.
- Five pushes with `word_ready`=0 and FIFO_DEPTH=4 → `desc_full`=1 after the 4th push; the 5th is dropped; `overflow`=1 and stays 1; after draining, exactly 4 descriptors appear in push order.
- FIFO full with `word_ready`=1: push coincides with the last-word handshake → push accepted, count stays 4, `overflow` stays 0.
- `in_valid`=1 with `ena`=0 → no push, count unchanged, `overflow`=0; an in-progress drain continues.
- `rst` pulsed low during word 3 of a descriptor → all outputs go to reset values immediately; after release, `word_valid` stays 0 until a new push.

Source files
------------

// File: rtl/orb_descriptor_drain_pkg.sv
// Shared constants and FSM state for the rBRIEF descriptor drain.
package orb_descriptor_drain_pkg;

  localparam int DEF_WIDTH_DESC = 256;
  localparam int DEF_WIDTH_WORD = 32;
  localparam int DEF_NW = DEF_WIDTH_DESC / DEF_WIDTH_WORD;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/orb_descriptor_drain_desc_fifo.sv
// Register FIFO of whole descriptors with a show-ahead head.
module desc_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Power-of-two depth lets the pointers wrap by overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/orb_descriptor_drain.sv
// Buffers rBRIEF descriptors and streams them out as words.
module orb_descriptor_drain
  import orb_descriptor_drain_pkg::*;
#(
  parameter int WIDTH_DESC = DEF_WIDTH_DESC,
  parameter int WIDTH_WORD = DEF_WIDTH_WORD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [WIDTH_DESC-1:0]         descriptors,
  input  logic                          in_valid,
  output logic                          desc_full,
  output logic [WIDTH_WORD-1:0]         word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          word_last,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   desc_count
);

  localparam int NW = WIDTH_DESC / WIDTH_WORD;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  logic [WIDTH_DESC-1:0] head;
  logic                  full;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nx;
  state_t                state;
  state_t                state_nx;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nx;
  logic                  last;
  logic                  fire;
  logic                  pop;
  logic                  push;

  assign word_valid = (state == SEND);
  assign last       = (idx == LAST);
  assign fire       = word_valid & word_ready;
  assign pop        = fire & last;
  // A full FIFO still takes a push when the head retires this cycle.
  assign push       = in_valid & ena & (~full | pop);

  desc_fifo #(
    .WIDTH (WIDTH_DESC),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (descriptors),
    .head  (head),
    .full  (full),
    .count (count)
  );

  always_comb begin
    count_nx = count;
    if (push && !pop) count_nx = count + CW'(1);
    else if (pop && !push) count_nx = count - CW'(1);
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (count_nx != '0) state_nx = SEND;
      end
      SEND: begin
        if (fire) begin
          idx_nx = last ? '0 : idx + IW'(1);
          if (last && count_nx == '0) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (in_valid && ena && !push) overflow <= 1'b1;
    end
  end

  assign word_out   = word_valid ?
                      head[idx*WIDTH_WORD +: WIDTH_WORD] : '0;
  assign word_last  = word_valid & last;
  assign desc_full  = full;
  assign desc_count = count;

endmodule

// File: tb/tb_orb_descriptor_drain.sv
// Directed self-checking bench for orb_descriptor_drain.
module tb_orb_descriptor_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [255:0] descriptors;
  logic         in_valid;
  logic         desc_full;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic         word_last;
  logic         overflow;
  logic [2:0]   desc_count;

  int errors = 0;
  int checks = 0;

  orb_descriptor_drain dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .descriptors (descriptors),
    .in_valid    (in_valid),
    .desc_full   (desc_full),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_last   (word_last),
    .overflow    (overflow),
    .desc_count  (desc_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input logic [31:0] b);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = b + 32'(k);
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b0; ena = 1'b1; in_valid = 1'b0;
    word_ready = 1'b0; descriptors = '0;
    #12;
    checks++;
    if ({word_valid, word_last, desc_full, overflow} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000",
               {word_valid, word_last, desc_full, overflow});
    end
    checks++;
    if (word_out !== 32'h0 || desc_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_data got=%h/%0d want=0/0", word_out, desc_count);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    word_ready = 1'b1;
    in_valid = 1'b1; descriptors = mk(32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (desc_count !== 3'd1) begin
      errors++;
      $display("FAIL single_count got=%0d want=1", desc_count);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (word_valid !== 1'b1 || word_out !== 32'(k) ||
          word_last !== (k == 7)) begin
        errors++;
        $display("FAIL single_word%0d got=%b/%h/%b want=1/%h/%b",
                 k, word_valid, word_out, word_last, k, k == 7);
      end
      @(negedge clk);
    end
    checks++;
    if (word_valid !== 1'b0 || desc_count !== 3'd0) begin
      errors++;
      $display("FAIL single_end got=%b/%0d want=0/0", word_valid, desc_count);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    logic r;
    logic v;
    int hs;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    hs = 0;
    @(negedge clk);
    word_ready = 1'b0;
    in_valid = 1'b1; descriptors = mk(32'h100);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 40 && hs < 8; c++) begin
      if (word_valid) begin
        checks++;
        if (word_out !== 32'h100 + 32'(hs) || word_last !== (hs == 7)) begin
          errors++;
          $display("FAIL bp_word%0d got=%h/%b want=%h/%b", hs, word_out,
                   word_last, 32'h100 + 32'(hs), hs == 7);
        end
      end
      r = pat[c % 4];
      v = word_valid;
      word_ready = r;
      @(negedge clk);
      if (v && r) hs++;
    end
    word_ready = 1'b0;
    checks++;
    if (hs != 8 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshakes got=%0d/%b want=8/0", hs, word_valid);
    end
  endtask

  task automatic test_ena_gate();
    @(negedge clk);
    word_ready = 1'b1;
    in_valid = 1'b1; descriptors = mk(32'h500);
    @(negedge clk);
    ena = 1'b0; descriptors = mk(32'h600);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (word_out !== 32'h500 + 32'(k) || desc_count !== 3'd1 ||
          overflow !== 1'b0) begin
        errors++;
        $display("FAIL ena_word%0d got=%h/%0d/%b want=%h/1/0", k,
                 word_out, desc_count, overflow, 32'h500 + 32'(k));
      end
      @(negedge clk);
    end
    in_valid = 1'b0; ena = 1'b1;
    checks++;
    if (word_valid !== 1'b0 || desc_count !== 3'd0) begin
      errors++;
      $display("FAIL ena_end got=%b/%0d want=0/0", word_valid, desc_count);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] b;
    @(negedge clk);
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; descriptors = mk(32'h2000 + 32'(i) * 32'h1000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (desc_full !== 1'b1 || desc_count !== 3'd4) begin
      errors++;
      $display("FAIL fpp_fill got=%b/%0d want=1/4", desc_full, desc_count);
    end
    word_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (word_out !== 32'h2000 + 32'(k)) begin
        errors++;
        $display("FAIL fpp_head%0d got=%h want=%h", k, word_out,
                 32'h2000 + 32'(k));
      end
      if (k == 7) begin
        in_valid = 1'b1; descriptors = mk(32'h6000);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (desc_count !== 3'd4 || overflow !== 1'b0 || desc_full !== 1'b1) begin
      errors++;
      $display("FAIL fpp_swap got=%0d/%b/%b want=4/0/1",
               desc_count, overflow, desc_full);
    end
    for (int d = 0; d < 4; d++) begin
      b = 32'h3000 + 32'(d) * 32'h1000;
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (word_valid !== 1'b1 || word_out !== b + 32'(k)) begin
          errors++;
          $display("FAIL fpp_d%0d_w%0d got=%b/%h want=1/%h",
                   d, k, word_valid, word_out, b + 32'(k));
        end
        @(negedge clk);
      end
    end
    checks++;
    if (word_valid !== 1'b0 || desc_count !== 3'd0) begin
      errors++;
      $display("FAIL fpp_end got=%b/%0d want=0/0", word_valid, desc_count);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] b;
    @(negedge clk);
    word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++;
        if (desc_full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full got=%b/%b want=1/0", desc_full, overflow);
        end
      end
      in_valid = 1'b1; descriptors = mk(32'h11000 + 32'(i) * 32'h1000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || desc_count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_drop got=%b/%0d want=1/4", overflow, desc_count);
    end
    word_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      b = 32'h11000 + 32'(d) * 32'h1000;
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (word_valid !== 1'b1 || word_out !== b + 32'(k)) begin
          errors++;
          $display("FAIL ovf_d%0d_w%0d got=%b/%h want=1/%h",
                   d, k, word_valid, word_out, b + 32'(k));
        end
        @(negedge clk);
      end
      if (d == 0) begin
        checks++;
        if (desc_full !== 1'b0 || desc_count !== 3'd3) begin
          errors++;
          $display("FAIL ovf_free got=%b/%0d want=0/3", desc_full, desc_count);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky got=%b/%b want=1/0", overflow, word_valid);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    word_ready = 1'b1;
    in_valid = 1'b1; descriptors = mk(32'h700);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (word_out !== 32'h703) begin
      errors++;
      $display("FAIL mr_word3 got=%h want=00000703", word_out);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({word_valid, word_last, desc_full, overflow} !== 4'b0 ||
        word_out !== 32'h0 || desc_count !== 3'd0) begin
      errors++;
      $display("FAIL mr_async got=%b/%h/%0d want=0000/0/0",
               {word_valid, word_last, desc_full, overflow},
               word_out, desc_count);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (word_valid !== 1'b0) begin
        errors++;
        $display("FAIL mr_quiet got=%b want=0", word_valid);
      end
    end
    in_valid = 1'b1; descriptors = mk(32'h900);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'h900) begin
      errors++;
      $display("FAIL mr_restart got=%b/%h want=1/00000900",
               word_valid, word_out);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_ena_gate();
    test_full_push_pop();
    test_overflow();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
